// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that drives the select pins of a shared 4:1 mux.
// Ownership is bounded by a hold-limit counter unless the owner asserts lock.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       lock,
  output logic [3:0] grant,
  output logic       gnt_valid,
  output logic       s0,
  output logic       s1,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       last_owner_q, last_owner_d;

  logic [3:0]       others;
  logic [2:0]       pick_all;
  logic [2:0]       pick_oth;
  logic             do_load;
  logic [1:0]       load_idx;

  // Round-robin search starting just after 'last' and wrapping back to it.
  // Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int off = 1; off <= 4; off++) begin
      idx = last + 2'(off);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Next-state logic: pick winners, handle release, preemption and hold counting.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gnt_valid_d  = gnt_valid_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    preempt_d    = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    do_load      = 1'b0;
    load_idx     = 2'd0;

    // While granted, last_owner is the current owner.
    others   = req & ~(4'b0001 << last_owner_q);
    pick_all = rr_pick(last_owner_q, req);
    pick_oth = rr_pick(last_owner_q, others);

    case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          do_load  = 1'b1;
          load_idx = pick_all[1:0];
        end
      end
      GRANT: begin
        if (!req[last_owner_q]) begin
          if (pick_oth[2]) begin
            do_load  = 1'b1;
            load_idx = pick_oth[1:0];
          end else begin
            // Release with nobody waiting: select lines keep their value.
            state_d     = IDLE;
            grant_d     = 4'b0000;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
          end
        end else if (!lock && (hold_cnt_q == HOLD_MAX) && pick_oth[2]) begin
          do_load   = 1'b1;
          load_idx  = pick_oth[1:0];
          preempt_d = 1'b1;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_load) begin
      state_d      = GRANT;
      grant_d      = 4'b0001 << load_idx;
      gnt_valid_d  = 1'b1;
      s0_d         = load_idx[1];
      s1_d         = load_idx[0];
      hold_cnt_d   = '0;
      last_owner_d = load_idx;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 4'b0000;
      gnt_valid_q  <= 1'b0;
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      preempt_q    <= 1'b0;
      hold_cnt_q   <= '0;
      last_owner_q <= 2'd3;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gnt_valid_q  <= gnt_valid_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      preempt_q    <= preempt_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign grant     = grant_q;
  assign gnt_valid = gnt_valid_q;
  assign s0        = s0_q;
  assign s1        = s1_q;
  assign preempt   = preempt_q;

endmodule
